kmeans_apb_master: RTL and testbench

Single-outstanding APB master that sits directly upstream of the Kmeans accelerator's APB slave port. It converts a valid/ready command stream (register writes, point-RAM loads, result reads) into APB SETUP/ACCESS transactions. It returns one response per command, with read data or an error. It also latches the accelerator's interrupt into a sticky, software-clearable pending flag.

---
 rtl/kmeans_apb_pkg.sv | 23 ++
 rtl/kmeans_irq_latch.sv | 43 ++++
 rtl/kmeans_apb_master.sv | 138 +++++++++++++
 tb/tb_kmeans_apb_master.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_apb_pkg.sv
// Shared types and default sizing for the Kmeans APB master.
// Holds the FSM state encoding and the registered command layout.
// Defaults match the Kmeans accelerator's APB slave port.
package kmeans_apb_pkg;

   localparam int KM_ADDR_W      = 9;
   localparam int KM_DATA_W      = 91;
   localparam int KM_APB_TIMEOUT = 255;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic                 write;
      logic [KM_ADDR_W-1:0] addr;
      logic [KM_DATA_W-1:0] wdata;
   } km_cmd_t;

endpackage

// File: rtl/kmeans_irq_latch.sv
// Sticky interrupt flag: rising edge of interupt sets it, irq_clr clears it.
// Latency: irq_pending rises one cycle after the rising edge is sampled.
// No backpressure; a simultaneous edge and clear leaves the flag set.
module kmeans_irq_latch
   import kmeans_apb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic interupt,
   input  logic irq_clr,
   output logic irq_pending
);

   logic int_prev_q, int_prev_d;
   logic pend_q, pend_d;
   logic rise;

   // Edge detect against the previous sample; set takes priority over clear.
   always_comb begin
      int_prev_d = interupt;
      rise       = interupt & ~int_prev_q;
      pend_d     = pend_q;
      if (rise) begin
         pend_d = 1'b1;
      end else if (irq_clr) begin
         pend_d = 1'b0;
      end
   end

   // Edge register and sticky flag, both cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         int_prev_q <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         int_prev_q <= int_prev_d;
         pend_q     <= pend_d;
      end
   end

   assign irq_pending = pend_q;

endmodule

// File: rtl/kmeans_apb_master.sv
// Single-outstanding APB master turning a valid/ready command stream into APB transfers.
// Latency: accept -> SETUP +1, ACCESS +2, RESP +3 minimum; each pready-low cycle adds one.
// Backpressure: cmd_ready only in IDLE; response held in RESP until rsp_ready.
module kmeans_apb_master
   import kmeans_apb_pkg::*;
#(
   parameter int addrWidth      = KM_ADDR_W,
   parameter int dataWidth      = KM_DATA_W,
   parameter int TIMEOUT_CYCLES = KM_APB_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [addrWidth-1:0] cmd_addr,
   input  logic [dataWidth-1:0] cmd_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [dataWidth-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic                 psel,
   output logic                 penable,
   output logic                 pwrite,
   output logic [addrWidth-1:0] paddr,
   output logic [dataWidth-1:0] pwdata,
   input  logic                 pready,
   input  logic [dataWidth-1:0] prdata,
   input  logic                 interupt,
   output logic                 irq_pending,
   input  logic                 irq_clr
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
   // The wait that brings the count to CNT_MAX is the one that aborts.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   apb_state_e           state_q, state_d;
   km_cmd_t              cmd_q, cmd_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [dataWidth-1:0] rdata_q, rdata_d;
   logic                 err_q, err_d;

   // Next-state, command capture, timeout counting and APB/response outputs.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      psel      = 1'b0;
      penable   = 1'b0;
      pwrite    = 1'b0;
      paddr     = '0;
      pwdata    = '0;

      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               cmd_d   = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
               cnt_d   = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            psel    = 1'b1;
            pwrite  = cmd_q.write;
            paddr   = cmd_q.addr;
            pwdata  = cmd_q.wdata;
            state_d = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            pwrite  = cmd_q.write;
            paddr   = cmd_q.addr;
            pwdata  = cmd_q.wdata;
            if (pready) begin
               rdata_d = cmd_q.write ? '0 : prdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (cnt_q >= CNT_LAST) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_rdata = rdata_q;
            rsp_err   = err_q;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, command, counter and response registers; reset drops any in-flight command.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   kmeans_irq_latch u_irq (
      .clk         (clk),
      .rst         (rst),
      .interupt    (interupt),
      .irq_clr     (irq_clr),
      .irq_pending (irq_pending)
   );

endmodule

// File: tb/tb_kmeans_apb_master.sv
module tb_kmeans_apb_master;

   localparam int TO = 4;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [8:0]  cmd_addr;
   logic [90:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [90:0] rsp_rdata;
   logic        rsp_err;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [8:0]  paddr;
   logic [90:0] pwdata;
   logic        pready;
   logic [90:0] prdata;
   logic        interupt;
   logic        irq_pending;
   logic        irq_clr;

   int n_checks = 0;
   int n_fail   = 0;

   kmeans_apb_master #(
      .addrWidth      (9),
      .dataWidth      (91),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .pready      (pready),
      .prdata      (prdata),
      .interupt    (interupt),
      .irq_pending (irq_pending),
      .irq_clr     (irq_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [90:0] rand91();
      return {27'($urandom), $urandom, $urandom};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // One complete command; expected timing and data come from the pready-low count.
   task automatic do_txn(input string nm, input bit wr, input logic [8:0] addr,
                         input logic [90:0] wd, input int nlow, input logic [90:0] rd,
                         input int hold, input bit poke);
      bit          exp_err;
      int          r_cyc;
      int          waitc;
      logic [90:0] exp_rd;
      logic        exp_pen;
      exp_err = (nlow >= TO);
      r_cyc   = exp_err ? 2 + TO : 3 + nlow;
      exp_rd  = (exp_err || wr) ? 91'd0 : rd;

      n_checks++;
      if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle: cmd_ready=%b psel=%b, required 1/0", nm, cmd_ready, psel);
      end

      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      rsp_ready = 1'b0; pready = 1'b0;
      step();
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = rand91();

      for (int c = 1; c < r_cyc; c++) begin
         exp_pen = (c >= 2);
         if (c >= 2) begin
            pready = ((c - 2) >= nlow);
            prdata = pready ? rd : rand91();
         end
         n_checks++;
         if (psel !== 1'b1 || penable !== exp_pen || pwrite !== wr || paddr !== addr ||
             (wr && pwdata !== wd) || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s apb cycle %0d: psel=%b penable=%b pwrite=%b paddr=%h rsp_valid=%b cmd_ready=%b, required 1/%b/%b/%h/0/0",
                     nm, c, psel, penable, pwrite, paddr, rsp_valid, cmd_ready, exp_pen, wr, addr);
         end
         step();
      end
      pready = 1'b0;

      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_rdata !== exp_rd || psel !== 1'b0 ||
          penable !== 1'b0 || pwrite !== 1'b0 || paddr !== 9'd0 || pwdata !== 91'd0 ||
          cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s resp cycle %0d: rsp_valid=%b rsp_err=%b rsp_rdata=%h psel=%b penable=%b paddr=%h cmd_ready=%b, required 1/%b/%h/0/0/0/0",
                  nm, r_cyc, rsp_valid, rsp_err, rsp_rdata, psel, penable, paddr, cmd_ready, exp_err, exp_rd);
      end

      if (rsp_valid !== 1'b1) begin
         waitc  = 0;
         pready = 1'b1;
         while (rsp_valid !== 1'b1 && waitc < 4 * TO + 20) begin
            step();
            waitc++;
         end
         pready = 1'b0;
      end

      for (int h = 0; h < hold; h++) begin
         if (poke) begin
            cmd_valid = 1'b1;
            cmd_addr  = 9'($urandom);
         end
         step();
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_rdata !== exp_rd ||
             cmd_ready !== 1'b0 || psel !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold %0d: rsp_valid=%b rsp_err=%b rsp_rdata=%h cmd_ready=%b psel=%b, required 1/%b/%h/0/0",
                     nm, h, rsp_valid, rsp_err, rsp_rdata, cmd_ready, psel, exp_err, exp_rd);
         end
      end

      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || psel !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after handshake: rsp_valid=%b cmd_ready=%b psel=%b, required 0/1/0",
                  nm, rsp_valid, cmd_ready, psel);
      end
      if (cmd_ready !== 1'b1) reset_pulse();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 91'd0 ||
          psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== 9'd0 ||
          pwdata !== 91'd0 || irq_pending !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: cmd_ready=%b rsp_valid=%b rsp_err=%b psel=%b penable=%b pwrite=%b paddr=%h irq_pending=%b, required 1 and all others 0",
                  cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite, paddr, irq_pending);
      end
   endtask

   task automatic test_first_write();
      do_txn("write_1a5", 1'b1, 9'h004, 91'h1A5, 0, rand91(), 0, 1'b0);
   endtask

   task automatic test_wait_read();
      do_txn("read_wait", 1'b0, 9'h0FF, rand91(), 3, 91'h3C, 0, 1'b0);
   endtask

   task automatic test_timeout();
      do_txn("timeout_rd", 1'b0, 9'h010, rand91(), TO, 91'h55, 0, 1'b0);
      do_txn("timeout_wr", 1'b1, 9'h011, rand91(), TO + 2, rand91(), 0, 1'b0);
      do_txn("after_timeout", 1'b0, 9'h012, rand91(), 1, 91'h777, 0, 1'b0);
   endtask

   task automatic test_rsp_hold();
      do_txn("rsp_hold", 1'b0, 9'h020, rand91(), 1, 91'hABC, 5, 1'b1);
   endtask

   task automatic test_irq_same_cycle();
      interupt = 1'b0; irq_clr = 1'b1;
      step();
      n_checks++;
      if (irq_pending !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_pre: irq_pending=%b, required 0", irq_pending);
      end
      interupt = 1'b1; irq_clr = 1'b1;
      step();
      n_checks++;
      if (irq_pending !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_set_wins: irq_pending=%b, required 1", irq_pending);
      end
      irq_clr = 1'b1;
      step();
      n_checks++;
      if (irq_pending !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_clear_level_high: irq_pending=%b, required 0", irq_pending);
      end
      irq_clr = 1'b0;
      step();
      step();
      n_checks++;
      if (irq_pending !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_level_no_reset: irq_pending=%b, required 0", irq_pending);
      end
      interupt = 1'b0;
      step();
   endtask

   // Reference: pending is set by a 0->1 change of interupt between samples, else cleared by irq_clr.
   task automatic test_irq_random();
      bit last_int;
      bit pend;
      bit cur_int;
      bit cur_clr;
      interupt = 1'b0; irq_clr = 1'b1;
      step();
      last_int = 1'b0;
      pend     = 1'b0;
      for (int i = 0; i < 150; i++) begin
         cur_int  = ($urandom_range(0, 1) == 1);
         cur_clr  = ($urandom_range(0, 3) == 0);
         interupt = cur_int;
         irq_clr  = cur_clr;
         step();
         if (cur_int && !last_int) pend = 1'b1;
         else if (cur_clr)         pend = 1'b0;
         last_int = cur_int;
         n_checks++;
         if (irq_pending !== pend) begin
            n_fail++;
            $display("FAIL irq_random step %0d: irq_pending=%b, required %b", i, irq_pending, pend);
         end
      end
      interupt = 1'b0; irq_clr = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      interupt = 1'b0; irq_clr = 1'b0;
      step();
      interupt = 1'b1;
      step();
      interupt = 1'b0;
      n_checks++;
      if (irq_pending !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_irq_setup: irq_pending=%b, required 1", irq_pending);
      end
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h0AA; cmd_wdata = rand91();
      pready = 1'b0; rsp_ready = 1'b0;
      step();
      cmd_valid = 1'b0;
      step();
      n_checks++;
      if (psel !== 1'b1 || penable !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_access: psel=%b penable=%b, required 1/1", psel, penable);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || irq_pending !== 1'b0 ||
          cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_after: psel=%b penable=%b rsp_valid=%b irq_pending=%b cmd_ready=%b, required 0/0/0/0/1",
                  psel, penable, rsp_valid, irq_pending, cmd_ready);
      end
      pready = 1'b1; prdata = rand91(); rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks++;
         if (rsp_valid !== 1'b0 || psel !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_dropped cycle %0d: rsp_valid=%b psel=%b, required 0/0", i, rsp_valid, psel);
         end
      end
      pready = 1'b0; rsp_ready = 1'b0;
      do_txn("after_rst_mid", 1'b1, 9'h1F0, rand91(), 2, rand91(), 1, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 30; i++) begin
         do_txn("random_txn", ($urandom_range(0, 1) == 1), 9'($urandom), rand91(),
                $urandom_range(0, TO + 1), rand91(), $urandom_range(0, 2),
                ($urandom_range(0, 1) == 1));
      end
   endtask

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; pready = 1'b0; prdata = '0; interupt = 1'b0; irq_clr = 1'b0;
      test_reset();
      test_first_write();
      test_wait_read();
      test_timeout();
      test_rsp_hold();
      test_irq_same_cycle();
      test_irq_random();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
